// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, oversample factor
// and the baud-select to divisor table.
package uart_pkg;

    localparam int OVERSAMPLE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Multiplier applied to BASE_DIV for each sel code.
    localparam int SEL_MULT [8] = '{1, 2, 4, 8, 16, 32, 64, 128};

    // Full bclk_8 period in sysclk cycles for a given select code.
    function automatic int sel_divisor(input int base_div, input logic [2:0] sel);
        return base_div * SEL_MULT[sel];
    endfunction

endpackage

// File: rtl/brg.sv
// Baud-rate generator: 50% duty bclk_8 (8x oversample), bclk (baud) and a
// one-cycle tick aligned with each bclk_8 rising edge.
module brg
    import uart_pkg::*;
#(
    parameter int BASE_DIV = 8
) (
    input  logic       rst,
    input  logic       sysclk,
    input  logic [2:0] sel,
    output logic       bclk,
    output logic       bclk_8,
    output logic       tick
);

    localparam int MAX_HALF = BASE_DIV * 64;
    localparam int CNT_W    = $clog2(MAX_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_m1;
    logic [2:0]       sel_q;
    logic [1:0]       rise_cnt;

    // Last count value of a half period for the currently applied rate.
    always_comb begin
        half_m1 = CNT_W'(sel_divisor(BASE_DIV, sel_q) / 2 - 1);
    end

    // Half-period counter; a sel change restarts everything from zero with both clocks low.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            sel_q    <= 3'd0;
            cnt      <= '0;
            bclk_8   <= 1'b0;
            bclk     <= 1'b0;
            rise_cnt <= 2'd0;
            tick     <= 1'b0;
        end else if (sel != sel_q) begin
            sel_q    <= sel;
            cnt      <= '0;
            bclk_8   <= 1'b0;
            bclk     <= 1'b0;
            rise_cnt <= 2'd0;
            tick     <= 1'b0;
        end else if (cnt == half_m1) begin
            cnt    <= '0;
            bclk_8 <= ~bclk_8;
            tick   <= ~bclk_8;
            if (!bclk_8) begin
                rise_cnt <= rise_cnt + 2'd1;
                if (rise_cnt == 2'd3) begin
                    bclk <= ~bclk;
                end
            end
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 8x oversampling, driven by the brg tick.
//
// state | meaning
// IDLE  | waiting for a low sample (only when armed after a framing error)
// START | confirming the start bit on the 3rd tick after the falling sample
// DATA  | sampling 8 data bits, one every 8 ticks, LSB first
// STOP  | sampling the stop bit; high loads RDR, low is a framing error
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BASE_DIV = 8
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [2:0] sel,
    output logic [7:0] RDR,
    output logic       rxd_readyH,
    output logic       bclk_8,
    output logic       bclk
);

    logic       tick;
    logic [1:0] rxd_sync;
    logic       rxd_s;

    rx_state_t  state, state_nx;
    logic [2:0] tcnt, tcnt_nx;
    logic [2:0] bidx, bidx_nx;
    logic [7:0] shreg, shreg_nx;
    logic [7:0] rdr_nx;
    logic       ready_nx;
    logic       armed, armed_nx;

    brg #(
        .BASE_DIV (BASE_DIV)
    ) u_brg (
        .rst    (rst),
        .sysclk (sysclk),
        .sel    (sel),
        .bclk   (bclk),
        .bclk_8 (bclk_8),
        .tick   (tick)
    );

    assign rxd_s = rxd_sync[1];

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            rxd_sync <= 2'b11;
        end else begin
            rxd_sync <= {rxd_sync[0], rxd};
        end
    end

    // FSM state and receive datapath registers.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tcnt       <= 3'd0;
            bidx       <= 3'd0;
            shreg      <= 8'h00;
            RDR        <= 8'h00;
            rxd_readyH <= 1'b0;
            armed      <= 1'b1;
        end else begin
            state      <= state_nx;
            tcnt       <= tcnt_nx;
            bidx       <= bidx_nx;
            shreg      <= shreg_nx;
            RDR        <= rdr_nx;
            rxd_readyH <= ready_nx;
            armed      <= armed_nx;
        end
    end

    // Next-state and datapath updates; everything advances only on a tick.
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bidx_nx  = bidx;
        shreg_nx = shreg;
        rdr_nx   = RDR;
        ready_nx = rxd_readyH;
        armed_nx = armed;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!armed) begin
                        if (rxd_s) begin
                            armed_nx = 1'b1;
                        end
                    end else if (!rxd_s) begin
                        state_nx = START;
                        tcnt_nx  = 3'd0;
                    end
                end
                START: begin
                    if (tcnt == 3'd2) begin
                        if (!rxd_s) begin
                            state_nx = DATA;
                            tcnt_nx  = 3'd0;
                            bidx_nx  = 3'd0;
                            ready_nx = 1'b0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tcnt_nx = tcnt + 3'd1;
                    end
                end
                DATA: begin
                    if (tcnt == 3'(OVERSAMPLE - 1)) begin
                        shreg_nx = {rxd_s, shreg[7:1]};
                        tcnt_nx  = 3'd0;
                        if (bidx == 3'd7) begin
                            state_nx = STOP;
                        end else begin
                            bidx_nx = bidx + 3'd1;
                        end
                    end else begin
                        tcnt_nx = tcnt + 3'd1;
                    end
                end
                STOP: begin
                    if (tcnt == 3'(OVERSAMPLE - 1)) begin
                        tcnt_nx  = 3'd0;
                        state_nx = IDLE;
                        if (rxd_s) begin
                            rdr_nx   = shreg;
                            ready_nx = 1'b1;
                        end else begin
                            // Framing error: line must return high before the next start.
                            armed_nx = 1'b0;
                        end
                    end else begin
                        tcnt_nx = tcnt + 3'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written
// sequences for glitches, back-to-back frames, framing errors, rates and reset.
module tb_uart_receiver;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b0;
    logic       rxd    = 1'b1;
    logic [2:0] sel    = 3'd0;
    logic [7:0] RDR;
    logic       rxd_readyH;
    logic       bclk_8;
    logic       bclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int p8      = 8;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_rdr;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [8];

    uart_receiver #(
        .BASE_DIV (8)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rxd        (rxd),
        .sel        (sel),
        .RDR        (RDR),
        .rxd_readyH (rxd_readyH),
        .bclk_8     (bclk_8),
        .bclk       (bclk)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_cycles(8 * p8);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic set_sel(input logic [2:0] s);
        rxd = 1'b1;
        sel = s;
        p8  = 8 << s;
        wait_cycles(16 * p8);
    endtask

    // Cycles spanned by n consecutive periods of bclk (use_bclk=1) or bclk_8.
    task automatic measure(input bit use_bclk, input int n, output int cycles);
        logic prev;
        logic cur;
        int   t_start;
        int   rises;
        int   guard;
        cycles  = -1;
        t_start = 0;
        rises   = 0;
        guard   = 0;
        prev    = use_bclk ? bclk : bclk_8;
        while (rises <= n && guard < 20000) begin
            @(negedge sysclk);
            guard++;
            cur = use_bclk ? bclk : bclk_8;
            if (cur && !prev) begin
                if (rises == 0) t_start = cyc;
                rises++;
                if (rises == n + 1) cycles = cyc - t_start;
            end
            prev = cur;
        end
        if (cycles < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL measure timeout: got no %0d periods, expected them within 20000 cycles", n);
        end
    endtask

    initial begin
        int  meas;
        int  guard;
        vecs[0] = '{3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1};
        vecs[1] = '{3'd0, 8'h3C, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{3'd0, 8'h5A, 1'b1, 8'h5A, 1'b1};
        vecs[3] = '{3'd3, 8'h81, 1'b1, 8'h81, 1'b1};
        vecs[4] = '{3'd1, 8'h0F, 1'b1, 8'h0F, 1'b1};
        vecs[5] = '{3'd2, 8'h3C, 1'b0, 8'h0F, 1'b0};
        vecs[6] = '{3'd0, 8'hC3, 1'b1, 8'hC3, 1'b1};
        vecs[7] = '{3'd0, 8'h00, 1'b1, 8'h00, 1'b1};

        // Reset state
        wait_cycles(3);
        check("reset RDR", 32'(RDR), 32'h00);
        check("reset ready", 32'(rxd_readyH), 32'h0);
        check("reset bclk", 32'(bclk), 32'h0);
        check("reset bclk_8", 32'(bclk_8), 32'h0);
        rst = 1'b1;
        wait_cycles(3);
        check("first bclk_8 low", 32'(bclk_8), 32'h0);
        wait_cycles(1);
        check("first bclk_8 rise", 32'(bclk_8), 32'h1);
        wait_cycles(16 * p8);

        // Short low glitch must not start a frame
        rxd = 1'b0;
        wait_cycles(2 * p8);
        rxd = 1'b1;
        wait_cycles(12 * 8 * p8);
        check("glitch RDR", 32'(RDR), 32'h00);
        check("glitch ready", 32'(rxd_readyH), 32'h0);

        // Table of frames at various rates
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sel != sel) set_sel(vecs[i].sel);
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("vec%0d RDR", i), 32'(RDR), 32'(vecs[i].exp_rdr));
            check($sformatf("vec%0d ready", i), 32'(rxd_readyH), 32'(vecs[i].exp_ready));
            rxd = 1'b1;
            wait_cycles(2 * 8 * p8);
        end

        // Back-to-back 0xFF then 0x00; ready drops at start-bit confirm
        send_frame(8'hFF, 1'b1);
        check("b2b first RDR", 32'(RDR), 32'hFF);
        check("b2b first ready", 32'(rxd_readyH), 32'h1);
        rxd = 1'b0;
        wait_cycles(2 * p8);
        check("b2b ready before confirm", 32'(rxd_readyH), 32'h1);
        wait_cycles(4 * p8);
        check("b2b ready after confirm", 32'(rxd_readyH), 32'h0);
        check("b2b RDR held", 32'(RDR), 32'hFF);
        wait_cycles(2 * p8);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        check("b2b second RDR", 32'(RDR), 32'h00);
        check("b2b second ready", 32'(rxd_readyH), 32'h1);
        wait_cycles(2 * 8 * p8);

        // Framing error with the line staying low: no restart until it goes high
        send_frame(8'h3C, 1'b0);
        wait_cycles(68 * p8);
        rxd = 1'b1;
        wait_cycles(12 * 8 * p8);
        check("ferr RDR", 32'(RDR), 32'h00);
        check("ferr ready", 32'(rxd_readyH), 32'h0);
        send_frame(8'h5A, 1'b1);
        check("after ferr RDR", 32'(RDR), 32'h5A);
        check("after ferr ready", 32'(rxd_readyH), 32'h1);
        rxd = 1'b1;

        // Clock periods at sel=3
        set_sel(3'd3);
        measure(1'b0, 3, meas);
        check("sel3 bclk_8 3 periods", 32'(meas), 32'd192);
        measure(1'b1, 3, meas);
        check("sel3 bclk 3 periods", 32'(meas), 32'd1536);

        // sel change forces both clocks low in the next cycle
        guard = 0;
        while (!(bclk && bclk_8) && guard < 5000) begin
            @(negedge sysclk);
            guard++;
        end
        check("both clocks high before sel change", 32'(bclk && bclk_8), 32'h1);
        sel = 3'd0;
        p8  = 8;
        wait_cycles(1);
        check("sel change bclk_8", 32'(bclk_8), 32'h0);
        check("sel change bclk", 32'(bclk), 32'h0);
        measure(1'b0, 3, meas);
        check("sel0 bclk_8 3 periods", 32'(meas), 32'd24);
        wait_cycles(2 * 8 * p8);

        // Reset during data bit 4 of 0xA5
        rxd = 1'b0;
        wait_cycles(8 * p8);
        for (int i = 0; i < 4; i++) send_bit(vecs[0].data[i]);
        rxd = vecs[0].data[4];
        wait_cycles(4 * p8);
        rst = 1'b0;
        #1;
        check("midreset RDR", 32'(RDR), 32'h00);
        check("midreset ready", 32'(rxd_readyH), 32'h0);
        check("midreset bclk", 32'(bclk), 32'h0);
        check("midreset bclk_8", 32'(bclk_8), 32'h0);
        rxd = 1'b1;
        wait_cycles(4);
        rst = 1'b1;
        wait_cycles(2 * 8 * p8);
        check("post reset RDR", 32'(RDR), 32'h00);
        send_frame(8'hA5, 1'b1);
        check("post reset frame RDR", 32'(RDR), 32'hA5);
        check("post reset frame ready", 32'(rxd_readyH), 32'h1);
        rxd = 1'b1;
        wait_cycles(8 * p8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
